// File: rtl/memory_interface_handshake.sv
`default_nettype none
// ============================================================================
// Module      : memory_interface_handshake
// Description : Single-port data memory behind a valid/ready request
//               interface. One request may be outstanding at a time. Writes
//               honour a per-byte enable mask, and a programmable number of
//               wait states is inserted before each response. Misaligned or
//               out-of-range accesses get an error response and never touch
//               the memory.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_WIDTH : word width in bits (multiple of 8)
//   ADDR_WIDTH : byte-address width
//   DEPTH      : number of words (power of 2)
//   LATENCY    : wait-state cycles before the response (0..15)
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous reset, active low
//   request_valid  in   request present on address / write_* inputs
//   request_ready  out  block accepts a request this cycle (IDLE only)
//   write_enable   in   1 = write, 0 = read
//   address        in   byte address
//   write_data     in   write data
//   byte_enable    in   per-byte write mask (ignored for reads)
//   response_valid out  one-cycle pulse when the request completes
//   response_error out  access rejected (qualified by response_valid)
//   read_data      out  read result; held until the next read response
// ============================================================================
module memory_interface_handshake #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      request_valid,
    output logic                      request_ready,
    input  logic                      write_enable,
    input  logic [ADDR_WIDTH-1:0]     address,
    input  logic [DATA_WIDTH-1:0]     write_data,
    input  logic [DATA_WIDTH/8-1:0]   byte_enable,
    output logic                      response_valid,
    output logic                      response_error,
    output logic [DATA_WIDTH-1:0]     read_data
);

    localparam int          BPW       = DATA_WIDTH / 8;
    localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam longint      MEM_BYTES = longint'(DEPTH) * longint'(BPW);
    localparam logic [3:0]  CNT_INIT  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                   state;
    state_t                   next_state;
    logic [3:0]               count;

    // Request captured at the handshake edge
    logic                     lat_we;
    logic                     lat_err;
    logic [IDX_W-1:0]         lat_idx;
    logic [DATA_WIDTH-1:0]    lat_wdata;
    logic [BPW-1:0]           lat_be;

    // Decode of the live request inputs
    logic                     req_err;
    logic [IDX_W-1:0]         req_idx;

    // Request actually used for the memory access this edge
    logic                     acc_we;
    logic                     acc_err;
    logic [IDX_W-1:0]         acc_idx;
    logic [DATA_WIDTH-1:0]    acc_wdata;
    logic [BPW-1:0]           acc_be;

    logic                     handshake;
    logic                     do_access;

    logic [DATA_WIDTH-1:0]    mem [DEPTH];

    // Range check done in 64 bits so the limit cannot be truncated to the
    // address width; an out-of-range index is never used because the error
    // flag blocks the access.
    assign req_err = ((address % ADDR_WIDTH'(BPW)) != '0) ||
                     (64'(address) >= 64'(MEM_BYTES));
    assign req_idx = IDX_W'(address / ADDR_WIDTH'(BPW));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state, ready and access strobe
    // ------------------------------------------------------------------
    always_comb begin
        next_state    = state;
        request_ready = 1'b0;
        handshake     = 1'b0;
        do_access     = 1'b0;
        acc_we        = lat_we;
        acc_err       = lat_err;
        acc_idx       = lat_idx;
        acc_wdata     = lat_wdata;
        acc_be        = lat_be;
        case (state)
            IDLE: begin
                // Ready is forced low while reset is held.
                request_ready = reset;
                handshake     = request_valid && request_ready;
                // With zero latency the access happens on the accepting
                // edge itself, so it must use the live inputs.
                acc_we        = write_enable;
                acc_err       = req_err;
                acc_idx       = req_idx;
                acc_wdata     = write_data;
                acc_be        = byte_enable;
                if (handshake) begin
                    if (LATENCY == 0) begin
                        next_state = RESPOND;
                        do_access  = 1'b1;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (count == 4'd0) begin
                    next_state = RESPOND;
                    do_access  = 1'b1;
                end
            end
            RESPOND: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, wait counter and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count          <= 4'd0;
            lat_we         <= 1'b0;
            lat_err        <= 1'b0;
            lat_idx        <= '0;
            lat_wdata      <= '0;
            lat_be         <= '0;
            response_valid <= 1'b0;
            response_error <= 1'b0;
            read_data      <= '0;
        end else begin
            if (handshake) begin
                lat_we    <= write_enable;
                lat_err   <= req_err;
                lat_idx   <= req_idx;
                lat_wdata <= write_data;
                lat_be    <= byte_enable;
                count     <= CNT_INIT;
            end else if (state == WAIT && count != 4'd0) begin
                count <= count - 4'd1;
            end

            response_valid <= do_access;
            response_error <= do_access && acc_err;

            if (do_access) begin
                if (acc_err) begin
                    read_data <= '0;
                end else if (!acc_we) begin
                    read_data <= mem[acc_idx];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory array (not reset). An aborted request never reaches here
    // because reset returns the FSM to IDLE before the access edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (do_access && acc_we && !acc_err) begin
            for (int i = 0; i < BPW; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][i*8 +: 8] <= acc_wdata[i*8 +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_interface_handshake.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_interface_handshake
// Description : Self-checking bench for memory_interface_handshake. Drives a
//               LATENCY=2 instance and a LATENCY=0 instance through directed
//               scenarios and a randomized sequence, comparing against a
//               word/byte-level reference memory kept in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_interface_handshake;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;

    logic        rv2, rdy2, vld2, err2;
    logic [31:0] rd2;
    logic        rv0, rdy0, vld0, err0;
    logic [31:0] rd0;

    int total = 0;
    int bad   = 0;

    // Reference memory: key = inst*4096 + word index; per-byte known mask.
    logic [31:0] mval  [int];
    logic [3:0]  mknown[int];
    logic [31:0] exp_rd  [2];
    bit          rd_known[2];

    memory_interface_handshake #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(256), .LATENCY(2)
    ) dut2 (
        .clk(clk), .reset(reset),
        .request_valid(rv2), .request_ready(rdy2),
        .write_enable(we), .address(addr), .write_data(wdata), .byte_enable(be),
        .response_valid(vld2), .response_error(err2), .read_data(rd2)
    );

    memory_interface_handshake #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(256), .LATENCY(0)
    ) dut0 (
        .clk(clk), .reset(reset),
        .request_valid(rv0), .request_ready(rdy0),
        .write_enable(we), .address(addr), .write_data(wdata), .byte_enable(be),
        .response_valid(vld0), .response_error(err0), .read_data(rd0)
    );

    // inst 1 = LATENCY 2 instance, inst 0 = LATENCY 0 instance
    function automatic logic g_rdy(input int w);
        return (w != 0) ? rdy2 : rdy0;
    endfunction
    function automatic logic g_vld(input int w);
        return (w != 0) ? vld2 : vld0;
    endfunction
    function automatic logic g_err(input int w);
        return (w != 0) ? err2 : err0;
    endfunction
    function automatic logic [31:0] g_rd(input int w);
        return (w != 0) ? rd2 : rd0;
    endfunction
    task automatic set_rv(input int w, input logic v);
        if (w != 0) rv2 = v; else rv0 = v;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One complete request on instance w, checked against the model.
    task automatic xact(input int w, input logic iwe, input logic [31:0] ia,
                        input logic [31:0] iwd, input logic [3:0] ibe, input string tag);
        int          lat;
        int          n;
        int          key;
        bit          err_exp;
        logic [31:0] word;
        logic [3:0]  km;
        @(negedge clk);
        we = iwe; addr = ia; wdata = iwd; be = ibe;
        set_rv(w, 1'b1);
        n = 0;
        while (!g_rdy(w) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".ready"}, 32'(g_rdy(w)), 32'd1);
        @(posedge clk); #1;
        set_rv(w, 1'b0);
        lat = 1;
        while (!g_vld(w) && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        // Response appears LATENCY+1 cycles after the accepting cycle.
        chk({tag, ".latency"}, 32'(lat), (w != 0) ? 32'd3 : 32'd1);

        err_exp = (ia % 4 != 0) || (ia >= 32'd1024);
        key     = w * 4096 + int'(ia / 4);
        chk({tag, ".error"}, 32'(g_err(w)), 32'(err_exp));

        if (err_exp) begin
            exp_rd[w]   = 32'd0;
            rd_known[w] = 1'b1;
        end else if (iwe) begin
            word = mval.exists(key)   ? mval[key]   : 32'd0;
            km   = mknown.exists(key) ? mknown[key] : 4'd0;
            for (int b = 0; b < 4; b++) begin
                if (ibe[b]) begin
                    word[b*8 +: 8] = iwd[b*8 +: 8];
                    km[b]          = 1'b1;
                end
            end
            mval[key]   = word;
            mknown[key] = km;
        end else begin
            if (mknown.exists(key) && mknown[key] == 4'hF) begin
                exp_rd[w]   = mval[key];
                rd_known[w] = 1'b1;
            end else begin
                rd_known[w] = 1'b0;
            end
        end
        if (rd_known[w]) chk({tag, ".rdata"}, g_rd(w), exp_rd[w]);

        // Pulse lasts one cycle and the block is back in IDLE.
        @(posedge clk); #1;
        chk({tag, ".pulse"}, 32'(g_vld(w)), 32'd0);
        chk({tag, ".idle"},  32'(g_rdy(w)), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d[2];
        int          t[2];
        int          cyc;
        int          lowcnt;
        int          nresp;
        bit          drop;
        int          w;
        int          r;
        logic [31:0] a;

        reset = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        rv2 = 1'b0; rv0 = 1'b0;
        exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
        rd_known[0] = 1'b1; rd_known[1] = 1'b1;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("rst.ready2", 32'(rdy2), 32'd0);
        chk("rst.ready0", 32'(rdy0), 32'd0);
        chk("rst.valid2", 32'(vld2), 32'd0);
        chk("rst.error2", 32'(err2), 32'd0);
        chk("rst.rdata2", rd2, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst.release_ready2", 32'(rdy2), 32'd1);

        // ---------------- T1 ----------------
        xact(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "t1.wr");
        xact(1, 1'b0, 32'h10, 32'h0,        4'h0, "t1.rd");
        chk("t1.value", rd2, 32'hDEADBEEF);

        // ---------------- T2 ----------------
        xact(1, 1'b1, 32'h10, 32'h000000AA, 4'h1, "t2.wr");
        xact(1, 1'b0, 32'h10, 32'h0,        4'h0, "t2.rd");
        chk("t2.value", rd2, 32'hDEADBEAA);

        // byte_enable==0 write leaves memory unchanged
        xact(1, 1'b1, 32'h10, 32'h11223344, 4'h0, "be0.wr");
        xact(1, 1'b0, 32'h10, 32'h0,        4'h0, "be0.rd");

        // ---------------- T3 ----------------
        xact(1, 1'b1, 32'h0,   32'hCAFEF00D, 4'hF, "t3.wr0");
        xact(1, 1'b0, 32'h400, 32'h0,        4'h0, "t3.oor");
        chk("t3.oor_err", 32'(err2), 32'd0);  // pulse already gone
        xact(1, 1'b1, 32'h12,  32'hFFFFFFFF, 4'hF, "t3.mis_wr");
        xact(1, 1'b0, 32'h12,  32'h0,        4'h0, "t3.mis");
        xact(1, 1'b1, 32'h400, 32'h55555555, 4'hF, "t3.oor_wr");
        xact(1, 1'b0, 32'h0,   32'h0,        4'h0, "t3.rd0");
        chk("t3.value0", rd2, 32'hCAFEF00D);

        // ---------------- T4: request_valid held across two reads ----------------
        @(negedge clk);
        we = 1'b0; addr = 32'h10; rv2 = 1'b1;
        @(posedge clk); #1;
        addr   = 32'h0;
        cyc    = 0; lowcnt = 0; nresp = 0; drop = 1'b0;
        t[0] = -1; t[1] = -1; d[0] = '0; d[1] = '0;
        for (int k = 0; k < 16; k++) begin
            cyc++;
            if (drop) begin
                rv2  = 1'b0;
                drop = 1'b0;
            end
            if (!rdy2 && nresp == 0) lowcnt++;
            if (vld2 && nresp < 2) begin
                t[nresp] = cyc;
                d[nresp] = rd2;
                nresp++;
            end
            if (nresp == 1 && rdy2 && rv2) drop = 1'b1;
            if (nresp == 2 && !drop) break;
            @(posedge clk); #1;
        end
        rv2 = 1'b0;
        chk("t4.ready_low", 32'(lowcnt), 32'd3);
        chk("t4.nresp",     32'(nresp),  32'd2);
        chk("t4.spacing",   32'(t[1] - t[0]), 32'd4);
        chk("t4.data0",     d[0], mval[4096 + 4]);
        chk("t4.data1",     d[1], mval[4096 + 0]);
        exp_rd[1] = d[1];
        @(posedge clk); #1;

        // ---------------- T5: reset during WAIT ----------------
        xact(1, 1'b1, 32'h20, 32'h0, 4'hF, "t5.pre");
        @(negedge clk);
        we = 1'b1; addr = 32'h20; wdata = 32'h12345678; be = 4'hF; rv2 = 1'b1;
        @(posedge clk); #1;
        rv2 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t5.ready",  32'(rdy2), 32'd0);
        chk("t5.valid",  32'(vld2), 32'd0);
        chk("t5.error",  32'(err2), 32'd0);
        chk("t5.rdata",  rd2, 32'd0);
        chk("t5.rdata0", rd0, 32'd0);
        r = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (vld2) r++;
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (vld2) r++;
        end
        chk("t5.no_response", 32'(r), 32'd0);
        exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
        rd_known[0] = 1'b1; rd_known[1] = 1'b1;
        xact(1, 1'b0, 32'h20, 32'h0, 4'h0, "t5.rd");
        chk("t5.value", rd2, 32'h0);

        // ---------------- T6: zero-latency instance ----------------
        xact(0, 1'b1, 32'h3FC, 32'hA5A51234, 4'hF, "t6.wr");
        xact(0, 1'b0, 32'h3FC, 32'h0,        4'h0, "t6.rd");
        chk("t6.value", rd0, 32'hA5A51234);
        xact(0, 1'b0, 32'h3FD, 32'h0,        4'h0, "t6.mis");

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 60; i++) begin
            w = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r < 7) begin
                a = $urandom_range(0, 8);
                if (a == 32'd8) a = 32'd255;
                a = a * 4;
            end else if (r == 7) begin
                a = 4 * $urandom_range(0, 255) + $urandom_range(1, 3);
            end else if (r == 8) begin
                a = 32'd1024 + 4 * $urandom_range(0, 100);
            end else begin
                a = 32'hFFFFFFFC;
            end
            xact(w, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
